// File: rtl/reg_bank.sv
// Integer register file x1..x31 (x0 reads zero): two zero-latency read ports, one-hot write, no backpressure.
// Optional write-first forwarding on read ports when REGBANK_BYPASS_EN is defined; adds a debug write counter and sticky multi-hot flag.
module reg_bank #(
    parameter logic [31:0] SP_RESET  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           regA_add,
    input  logic [4:0]           regB_add,
    input  logic [31:1]          wrAddr,
    input  logic [31:0]          wr_data,
    output logic [31:0]          dataA,
    output logic [31:0]          dataB,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic                 wr_err
);

    logic [31:0] regs [32];
    logic        wr_any;
    logic        wr_multi;
    logic        wr_valid;

    assign wr_any   = |wrAddr;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign wr_multi = |(wrAddr & (wrAddr - 31'd1));
    assign wr_valid = wr_any & ~wr_multi;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= (k == 2) ? SP_RESET : 32'h0;
            end
            wr_count <= '0;
            wr_err   <= 1'b0;
        end else begin
            if (wr_valid) begin
                for (int k = 1; k < 32; k++) begin
                    if (wrAddr[k]) begin
                        regs[k] <= wr_data;
                    end
                end
                if (wr_count != {CNT_WIDTH{1'b1}}) begin
                    wr_count <= wr_count + CNT_WIDTH'(1);
                end
            end
            if (wr_multi) begin
                wr_err <= 1'b1;
            end
        end
    end

`ifdef REGBANK_BYPASS_EN
    logic [31:0] wr_sel;
    assign wr_sel = {wrAddr, 1'b0};
`endif

    always_comb begin
        dataA = regs[regA_add];
`ifdef REGBANK_BYPASS_EN
        if (wr_valid && wr_sel[regA_add]) begin
            dataA = wr_data;
        end
`endif
        if (regA_add == 5'd0) begin
            dataA = 32'h0;
        end
    end

    always_comb begin
        dataB = regs[regB_add];
`ifdef REGBANK_BYPASS_EN
        if (wr_valid && wr_sel[regB_add]) begin
            dataB = wr_data;
        end
`endif
        if (regB_add == 5'd0) begin
            dataB = 32'h0;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (SP_RESET=0x1000, CNT_WIDTH=4); honours REGBANK_BYPASS_EN.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  regA_add;
    logic [4:0]  regB_add;
    logic [31:1] wrAddr;
    logic [31:0] wr_data;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [3:0]  wr_count;
    logic        wr_err;

    int checks   = 0;
    int failures = 0;

    reg_bank #(
        .SP_RESET (32'h0000_1000),
        .CNT_WIDTH(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .regA_add(regA_add),
        .regB_add(regB_add),
        .wrAddr  (wrAddr),
        .wr_data (wr_data),
        .dataA   (dataA),
        .dataB   (dataB),
        .wr_count(wr_count),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:1] sel(input int k);
        logic [31:0] v;
        v = 32'h1 << k;
        return v[31:1];
    endfunction

    initial begin
        logic [31:0] exp_same;

        reset    = 1'b1;
        regA_add = 5'd0;
        regB_add = 5'd0;
        wrAddr   = '0;
        wr_data  = 32'h0;
        tick();
        tick();
        reset    = 1'b0;
        regA_add = 5'd2;
        regB_add = 5'd5;
        #1;
        check("rst_x2", dataA, 32'h0000_1000);
        check("rst_x5", dataB, 32'h0);
        check("rst_cnt", {28'h0, wr_count}, 32'd0);
        check("rst_err", {31'h0, wr_err}, 32'd0);

        // x7 = DEADBEEF (wrAddr value 1<<6 selects bit 7 of [31:1])
        wrAddr  = 31'(1) << 6;
        wr_data = 32'hDEAD_BEEF;
        tick();
        wrAddr   = '0;
        regA_add = 5'd7;
        #1;
        check("wr_x7", dataA, 32'hDEAD_BEEF);
        check("cnt_1", {28'h0, wr_count}, 32'd1);

        // Same-cycle read/write of x7
        wrAddr  = sel(7);
        wr_data = 32'h1234_5678;
        #1;
`ifdef REGBANK_BYPASS_EN
        exp_same = 32'h1234_5678;
`else
        exp_same = 32'hDEAD_BEEF;
`endif
        check("same_cyc_x7", dataA, exp_same);
        tick();
        wrAddr = '0;
        #1;
        check("next_cyc_x7", dataA, 32'h1234_5678);
        check("cnt_2", {28'h0, wr_count}, 32'd2);

        // Empty write with x0 read on both ports
        wrAddr   = '0;
        wr_data  = 32'hFFFF_FFFF;
        regA_add = 5'd0;
        regB_add = 5'd0;
        #1;
        check("x0_a", dataA, 32'h0);
        check("x0_b", dataB, 32'h0);
        tick();
        check("x0_a_after", dataA, 32'h0);
        check("cnt_empty", {28'h0, wr_count}, 32'd2);
        check("err_empty", {31'h0, wr_err}, 32'd0);

        // Seed x3/x4, then multi-hot write must change nothing but wr_err
        wrAddr = sel(3); wr_data = 32'h0000_0033; tick();
        wrAddr = sel(4); wr_data = 32'h0000_0044; tick();
        wrAddr   = sel(3) | sel(4);
        wr_data  = 32'hAAAA_AAAA;
        regA_add = 5'd3;
        regB_add = 5'd4;
        #1;
        check("multi_nofwd_a", dataA, 32'h0000_0033);
        check("multi_nofwd_b", dataB, 32'h0000_0044);
        tick();
        wrAddr = '0;
        #1;
        check("multi_x3", dataA, 32'h0000_0033);
        check("multi_x4", dataB, 32'h0000_0044);
        check("multi_err", {31'h0, wr_err}, 32'd1);
        check("multi_cnt", {28'h0, wr_count}, 32'd4);
        repeat (10) tick();
        check("err_sticky", {31'h0, wr_err}, 32'd1);

        // Both ports same register while another register is written
        regA_add = 5'd3;
        regB_add = 5'd3;
        wrAddr   = sel(5);
        wr_data  = 32'h0000_0055;
        #1;
        check("dual_a", dataA, 32'h0000_0033);
        check("dual_b", dataB, 32'h0000_0033);
        tick();
        wrAddr   = '0;
        regB_add = 5'd5;
        #1;
        check("x5", dataB, 32'h0000_0055);
        check("cnt_5", {28'h0, wr_count}, 32'd5);

        // 20 valid writes to x10: counter reaches 15 after 10 and then holds
        for (int i = 0; i < 20; i++) begin
            wrAddr  = sel(10);
            wr_data = 32'(i + 100);
            tick();
            if (i == 9) begin
                check("cnt_reach_f", {28'h0, wr_count}, 32'd15);
            end
        end
        wrAddr   = '0;
        regA_add = 5'd10;
        #1;
        check("cnt_sat", {28'h0, wr_count}, 32'd15);
        check("x10_last", dataA, 32'd119);

        // x9 written normally, then reset with a concurrent write to x9
        wrAddr = sel(9); wr_data = 32'h0000_0077; tick();
        reset    = 1'b1;
        wrAddr   = sel(9);
        wr_data  = 32'h0000_0005;
        tick();
        reset    = 1'b0;
        wrAddr   = '0;
        regA_add = 5'd9;
        regB_add = 5'd2;
        #1;
        check("rst_wr_x9", dataA, 32'h0);
        check("rst_wr_x2", dataB, 32'h0000_1000);
        check("rst_wr_cnt", {28'h0, wr_count}, 32'd0);
        check("rst_wr_err", {31'h0, wr_err}, 32'd0);

        wrAddr = sel(9); wr_data = 32'h0000_0005; tick();
        wrAddr = '0;
        #1;
        check("post_rst_x9", dataA, 32'h0000_0005);
        check("post_rst_cnt", {28'h0, wr_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
